// File: rtl/intc_pkg.sv
// intc_pkg: shared constants and FSM state type for the interrupt controller.
`default_nettype none

package intc_pkg;

  localparam int NIRQ    = 4;
  localparam int CAUSE_W = $clog2(NIRQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/intc_sync.sv
// +--------------------------------------------------------------------------+
// | intc_sync: per-line 2-flop irq synchronizer (used with INTC_SYNC_EN).     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module intc_sync #(
  parameter int W = 4
) (
  input  logic         clk_pc,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;

  // load_i primes both stages straight from the pin so a level held across
  // reset release is never seen as a rising edge.
  always_ff @(posedge clk_pc or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else if (load_i) begin
      sync1_q <= d_i;
      sync2_q <= d_i;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

`default_nettype wire

// File: rtl/intc.sv
// +--------------------------------------------------------------------------+
// | intc: edge-triggered, fixed-priority interrupt controller (INTC_SYNC_EN  |
// | adds an input synchronizer). rev 1.0                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module intc #(
  parameter int NIRQ = 4
) (
  input  logic                       clk_pc,
  input  logic                       rst,
  input  logic [NIRQ-1:0]            irq,
  input  logic                       mask_we,
  input  logic [NIRQ-1:0]            mask_wdata,
  input  logic                       iret,
  output logic                       intr,
  output logic [intc_pkg::CAUSE_W-1:0] cause,
  output logic [NIRQ-1:0]            pending,
  output logic                       in_service
);

  import intc_pkg::*;

  state_e              state_q, state_d;
  logic [CAUSE_W-1:0]  cause_q, cause_d;
  logic [NIRQ-1:0]     pending_q, pending_d;
  logic [NIRQ-1:0]     mask_q;
  logic [NIRQ-1:0]     irq_s;
  logic [NIRQ-1:0]     irq_dly_q;
  logic                armed_q;
  logic [NIRQ-1:0]     rise;
  logic [NIRQ-1:0]     req;
  logic [NIRQ-1:0]     clr;
  logic [CAUSE_W-1:0]  sel;

`ifdef INTC_SYNC_EN
  intc_sync #(.W(NIRQ)) u_sync (
    .clk_pc (clk_pc),
    .rst    (rst),
    .load_i (~armed_q),
    .d_i    (irq),
    .q_o    (irq_s)
  );
`else
  assign irq_s = irq;
`endif

  // armed_q stays low for the first clock after reset so that clock only
  // loads the edge-detector history instead of detecting against zero.
  always_ff @(posedge clk_pc or posedge rst) begin
    if (rst) begin
      armed_q   <= 1'b0;
      irq_dly_q <= '0;
      mask_q    <= '0;
      pending_q <= '0;
      cause_q   <= '0;
      state_q   <= IDLE;
    end else begin
      armed_q   <= 1'b1;
      irq_dly_q <= armed_q ? irq_s : irq;
      if (mask_we) mask_q <= mask_wdata;
      pending_q <= pending_d;
      cause_q   <= cause_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    rise    = armed_q ? (irq_s & ~irq_dly_q) : '0;
    req     = pending_q & mask_q;
    sel     = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req[i]) sel = CAUSE_W'(i);
    end
    clr     = '0;
    cause_d = cause_q;
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d  = FIRE;
          cause_d  = sel;
          clr[sel] = 1'b1;
        end
      end
      FIRE:    state_d = SERVICE;
      SERVICE: if (iret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A fresh edge on the line being taken keeps its pending bit set.
    pending_d = (pending_q & ~clr) | rise;
  end

  assign intr       = (state_q == FIRE);
  assign in_service = (state_q != IDLE);
  assign cause      = cause_q;
  assign pending    = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_intc.sv
// tb_intc: randomized + directed check of intc against a cycle-level reference model.
`default_nettype none

module tb_intc;

`ifdef INTC_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic       clk_pc = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] irq = 4'b0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = 4'b0;
  logic       iret = 1'b0;
  logic       intr;
  logic [1:0] cause;
  logic [3:0] pending;
  logic       in_service;

  intc #(.NIRQ(4)) dut (
    .clk_pc     (clk_pc),
    .rst        (rst),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .iret       (iret),
    .intr       (intr),
    .cause      (cause),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk_pc = ~clk_pc;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase 0 = waiting, 1 = request pulse, 2 = handler running.
  int       m_phase;
  int       m_cause;
  int       m_clk;
  bit [3:0] m_pend;
  bit [3:0] m_mask;
  bit [3:0] m_hist[$];

  function automatic bit [3:0] seen(input int k);
    int idx;
    idx = (k < 1) ? 1 : k;
    return m_hist[idx-1];
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cause = 0; m_clk = 0;
    m_pend = 4'b0; m_mask = 4'b0;
    m_hist.delete();
  endtask

  task automatic model_clock();
    bit [3:0] edges, req, nextp;
    int lowest;
    if (rst) begin
      model_reset();
      return;
    end
    m_clk++;
    m_hist.push_back(irq);
    edges = 4'b0;
    if (m_clk >= 2) edges = seen(m_clk - D) & ~seen(m_clk - 1 - D);
    req   = m_pend & m_mask;
    nextp = m_pend;
    if (m_phase == 0) begin
      if (req != 4'b0) begin
        lowest = 3;
        while (lowest > 0 && !(req[lowest-1] == 1'b0 ? 1'b0 : 1'b1)) lowest--;
        for (int i = 3; i >= 0; i--) if (req[i]) lowest = i;
        m_cause = lowest;
        nextp[lowest] = 1'b0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (iret) begin
      m_phase = 0;
    end
    m_pend = nextp | edges;
    if (mask_we) m_mask = mask_wdata;
  endtask

  task automatic compare_all();
    check_eq("intr", intr, (m_phase == 1));
    check_eq("in_service", in_service, (m_phase != 0));
    check_eq("cause", cause, m_cause);
    check_eq("pending", pending, m_pend);
  endtask

  task automatic cyc();
    @(posedge clk_pc);
    model_clock();
    #1;
    compare_all();
    mask_we = 1'b0;
    iret    = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_intr(output int k);
    k = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      k++;
      if (intr) break;
    end
    check_eq("intr_seen", intr, 1'b1);
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we = 1'b1; mask_wdata = m;
    cyc();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_intr", intr, 1'b0);
    check_eq("rst_in_service", in_service, 1'b0);
    check_eq("rst_cause", cause, 2'd0);
    check_eq("rst_pending", pending, 4'd0);
    model_reset();
    run(2);
    @(negedge clk_pc);
    rst = 1'b0;
  endtask

  int k;
  int cnt;

  initial begin
    model_reset();
    // REQ-032: line held high through reset is not an edge.
    irq = 4'b0010;
    do_reset();
    write_mask(4'b1111);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin cyc(); if (intr) cnt++; end
    check_eq("held_no_intr", cnt, 0);
    irq = 4'b0000; run(D + 2);
    irq = 4'b0010;
    wait_intr(k);
    check_eq("s1_cause", cause, 2'd1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin cyc(); if (intr) cnt++; end
    check_eq("s1_single_intr", cnt, 0);
    iret = 1'b1; cyc();

    // REQ-033: simultaneous edges, priority and the mandatory idle gap.
    irq = 4'b0000; run(D + 2);
    irq = 4'b1010;
    wait_intr(k);
    check_eq("s2_cause1", cause, 2'd1);
    check_eq("s2_pending", pending, 4'b1000);
    cyc();
    iret = 1'b1; cyc();
    check_eq("s2_idle_gap", intr, 1'b0);
    cyc();
    check_eq("s2_intr2", intr, 1'b1);
    check_eq("s2_cause3", cause, 2'd3);
    cyc();
    iret = 1'b1; cyc();

    // REQ-034: masked edge stays pending until enabled.
    write_mask(4'b0000);
    irq = 4'b0000; run(D + 2);
    irq = 4'b0100; run(D + 3);
    check_eq("s3_pending", pending, 4'b0100);
    check_eq("s3_no_intr", intr, 1'b0);
    write_mask(4'b0100);
    cyc();
    check_eq("s3_intr", intr, 1'b1);
    check_eq("s3_cause", cause, 2'd2);
    cyc();

    // REQ-035: edge during service waits for iret; iret outside service ignored.
    write_mask(4'b1111);
    irq = 4'b0000; run(D + 2);
    irq = 4'b0001; run(D + 1);
    check_eq("s4_pending0", pending[0], 1'b1);
    check_eq("s4_no_intr", intr, 1'b0);
    iret = 1'b1; cyc();
    wait_intr(k);
    check_eq("s4_cause0", cause, 2'd0);
    cyc();
    iret = 1'b1; cyc();
    for (int i = 0; i < 3; i++) begin iret = 1'b1; cyc(); end
    check_eq("s4_idle_iret", in_service, 1'b0);

    // REQ-036: reset during service with pending 0001 discards everything.
    irq = 4'b0000; run(D + 2);
    irq = 4'b0010;
    wait_intr(k);
    cyc();
    irq = 4'b0011; run(D + 2);
    check_eq("s5_pre_pending", pending, 4'b0001);
    do_reset();
    write_mask(4'b1111);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin cyc(); if (intr) cnt++; end
    check_eq("s5_no_intr", cnt, 0);

    // REQ-037: latency from first sampling edge to intr.
    irq = 4'b0000; run(D + 3);
    irq = 4'b0001;
    wait_intr(k);
    check_eq("latency", k, D + 2);
    cyc();
    iret = 1'b1; cyc();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) irq = 4'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        mask_we = 1'b1; mask_wdata = 4'($urandom);
      end
      if ($urandom_range(0, 3) == 0) iret = 1'b1;
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
